// File: rtl/lgn_mnist_pkg.sv
// lgn_mnist_pkg: sizes, two-input gate truth-table encodings and the default gate-layer wiring tables.
package lgn_mnist_pkg;
   localparam int GROUPS      = 10;
   localparam int GROUP_SIZE  = 25;
   localparam int FRAME_BYTES = 32;
   localparam int GATES       = GROUPS * GROUP_SIZE;
   localparam int IMG_BITS    = FRAME_BYTES * 8;
   // Truth table bit (2a+b) holds the gate result for inputs a,b.
   localparam logic [3:0] OP_ZERO      = 4'b0000;
   localparam logic [3:0] OP_AND       = 4'b1000;
   localparam logic [3:0] OP_A_NOT_B   = 4'b0100;
   localparam logic [3:0] OP_A         = 4'b1100;
   localparam logic [3:0] OP_NOT_A_B   = 4'b0010;
   localparam logic [3:0] OP_B         = 4'b1010;
   localparam logic [3:0] OP_XOR       = 4'b0110;
   localparam logic [3:0] OP_OR        = 4'b1110;
   localparam logic [3:0] OP_NOR       = 4'b0001;
   localparam logic [3:0] OP_XNOR      = 4'b1001;
   localparam logic [3:0] OP_NOT_B     = 4'b0101;
   localparam logic [3:0] OP_A_OR_NB   = 4'b1101;
   localparam logic [3:0] OP_NOT_A     = 4'b0011;
   localparam logic [3:0] OP_NA_OR_B   = 4'b1011;
   localparam logic [3:0] OP_NAND      = 4'b0111;
   localparam logic [3:0] OP_ONE       = 4'b1111;
   typedef logic [GATES-1:0][3:0] op_tab_t;
   typedef logic [GATES-1:0][7:0] idx_tab_t;
   function automatic idx_tab_t identity_idx();
      idx_tab_t t;
      for (int j = 0; j < GATES; j++) t[j] = 8'(j);
      return t;
   endfunction
   function automatic logic gate_eval(input logic [3:0] op, input logic a, input logic b);
      return op[{a, b}];
   endfunction
   localparam op_tab_t  OP = {GATES{OP_A}};
   localparam idx_tab_t A  = identity_idx();
   localparam idx_tab_t B  = identity_idx();
endpackage

// File: rtl/lgn_mnist_gate_layer.sv
// lgn_mnist_gate_layer: combinational layer of GATES two-input gates wired from the package tables.
module lgn_mnist_gate_layer
   import lgn_mnist_pkg::*;
(
   input  logic [IMG_BITS-1:0] x,
   output logic [GATES-1:0]    y
);
   logic unused_bits;
   assign unused_bits = ^x;
   for (genvar j = 0; j < GATES; j++) begin : g_gate
      assign y[j] = gate_eval(OP[j], x[A[j]], x[B[j]]);
   end
endmodule

// File: rtl/rejunity_lgn_mnist.sv
// rejunity_lgn_mnist: streaming 16x16 binary digit classifier (byte capture, gate layer, group popcount, argmax).
// Define LGN_PIPE_EN to register the gate outputs before popcount (one extra edge of latency).
module rejunity_lgn_mnist
   import lgn_mnist_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   logic [4:0] cnt;
   logic [FRAME_BYTES-1:0][7:0] img, img_nxt;
   logic [IMG_BITS-1:0] frame;
   logic done, last, upd;
   logic [GATES-1:0] gates, g;
   logic [7:0] score [GROUPS];
   logic [7:0] best_s;
   logic [3:0] best_i, cls;
   logic unused_uio;
   assign unused_uio = ^uio_in[6:0];
   assign last = ena && cnt == 5'(FRAME_BYTES - 1);
   always_comb begin
      img_nxt = img;
      img_nxt[cnt] = ui_in;
   end
   // The completing edge snapshots the buffer including the byte being written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         img <= '0;
         frame <= '0;
         done <= 1'b0;
      end else begin
         done <= last;
         if (ena) begin
            cnt <= cnt + 5'd1;
            img <= img_nxt;
         end
         if (last) frame <= img_nxt;
      end
   end
   lgn_mnist_gate_layer u_gates (
      .x(frame),
      .y(gates)
   );
`ifdef LGN_PIPE_EN
   logic [GATES-1:0] g_q;
   logic done_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_q <= '0;
         done_q <= 1'b0;
      end else begin
         g_q <= gates;
         done_q <= done;
      end
   end
   assign g = g_q;
   assign upd = done_q;
`else
   assign g = gates;
   assign upd = done;
`endif
   always_comb begin
      for (int c = 0; c < GROUPS; c++) begin
         score[c] = '0;
         for (int k = 0; k < GROUP_SIZE; k++) score[c] = score[c] + 8'(g[c*GROUP_SIZE+k]);
      end
   end
   // Strict compare keeps the lowest index on ties.
   always_comb begin
      best_s = score[0];
      best_i = '0;
      for (int c = 1; c < GROUPS; c++) begin
         best_i = score[c] > best_s ? 4'(c) : best_i;
         best_s = score[c] > best_s ? score[c] : best_s;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         uo_out <= '0;
         cls <= '0;
      end else if (upd && !uio_in[7]) begin
         uo_out <= best_s;
         cls <= best_i;
      end
   end
   assign uio_out = {4'b0000, cls};
   assign uio_oe = 8'h0F;
endmodule

// File: tb/tb_rejunity_lgn_mnist.sv
// tb_rejunity_lgn_mnist: directed frames with a due-edge scoreboard checked by a negedge monitor.
module tb_rejunity_lgn_mnist;
`ifdef LGN_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic clk = 1'b0;
   logic rst_n, ena;
   logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
   typedef struct {
      int due;
      logic [3:0] idx;
      logic [7:0] sc;
      string name;
   } exp_t;
   exp_t q[$];
   int edges = 0;
   int total = 0;
   int bad = 0;
   logic [3:0] prev_i = '0;
   logic [7:0] prev_s = '0;
   rejunity_lgn_mnist dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .ui_in(ui_in),
      .uio_in(uio_in),
      .uo_out(uo_out),
      .uio_out(uio_out),
      .uio_oe(uio_oe)
   );
   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;
   task automatic check(input string n, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (edge %0d)", n, act, req, edges);
      end
   endtask
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= edges) begin
         exp_t e;
         e = q.pop_front();
         if (e.due < edges) begin
            bad++;
            total++;
            $display("FAIL %s: check missed at edge %0d", e.name, edges);
         end else begin
            check({e.name, ".score"}, uo_out, e.sc);
            check({e.name, ".class"}, uio_out, {4'b0000, e.idx});
            check({e.name, ".oe"}, uio_oe, 8'h0F);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input int due, input logic [3:0] i, input logic [7:0] s, input string n);
      exp_t e;
      e.due = due;
      e.idx = i;
      e.sc = s;
      e.name = n;
      q.push_back(e);
   endtask
   // gap inserts ena=0 cycles after byte 15; fz is uio_in[7] held through the update edge.
   task automatic send_frame(input logic [255:0] im, input logic [3:0] ei, input logic [7:0] es,
                             input logic fz, input int gap, input string n);
      int e;
      uio_in = {fz, 7'h00};
      for (int k = 0; k < 32; k++) begin
         ena = 1'b1;
         ui_in = im[8*k +: 8];
         tick();
         if (k == 15) begin
            for (int g = 0; g < gap; g++) begin
               ena = 1'b0;
               ui_in = 8'hA5;
               tick();
            end
         end
      end
      e = edges;
      push(e, prev_i, prev_s, {n, ".pre"});
      if (!fz) begin
         prev_i = ei;
         prev_s = es;
      end
      push(e + LAT, prev_i, prev_s, n);
      ena = 1'b0;
      ui_in = 8'h00;
      for (int k = 0; k < 3; k++) tick();
   endtask
   logic [255:0] im_zero, im_ones, im_c2, im_c9;
   initial begin
      im_zero = '0;
      im_ones = '1;
      im_c2 = '0;
      im_c9 = '0;
      for (int i = 50; i < 75; i++) im_c2[i] = 1'b1;
      for (int i = 225; i < 250; i++) im_c9[i] = 1'b1;
      rst_n = 1'b0;
      ena = 1'b0;
      ui_in = 8'h00;
      uio_in = 8'h00;
      tick();
      push(edges, 4'd0, 8'd0, "reset0");
      tick();
      push(edges, 4'd0, 8'd0, "reset1");
      rst_n = 1'b1;
      tick();
      send_frame(im_zero, 4'd0, 8'd0, 1'b0, 0, "zeros");
      send_frame(im_ones, 4'd0, 8'd25, 1'b0, 0, "ones_tie");
      send_frame(im_c2, 4'd2, 8'd25, 1'b0, 0, "class2");
      send_frame(im_c9, 4'd9, 8'd25, 1'b0, 0, "class9");
      send_frame(im_zero, 4'd0, 8'd0, 1'b1, 0, "frozen");
      send_frame(im_zero, 4'd0, 8'd0, 1'b0, 0, "unfrozen");
      send_frame(im_c9, 4'd9, 8'd25, 1'b0, 0, "class9b");
      for (int k = 0; k < 10; k++) begin
         ena = 1'b1;
         ui_in = im_ones[8*k +: 8];
         tick();
      end
      rst_n = 1'b0;
      ena = 1'b0;
      tick();
      push(edges, 4'd0, 8'd0, "midreset0");
      tick();
      push(edges, 4'd0, 8'd0, "midreset1");
      rst_n = 1'b1;
      prev_i = '0;
      prev_s = '0;
      send_frame(im_c2, 4'd2, 8'd25, 1'b0, 0, "after_reset");
      send_frame(im_zero, 4'd0, 8'd0, 1'b0, 0, "zeros2");
      send_frame(im_c2, 4'd2, 8'd25, 1'b0, 5, "ena_gap");
      for (int k = 0; k < 20 && q.size() > 0; k++) tick();
      if (q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: %0d checks still pending, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
